// File: rtl/reg_file_sys_ctrl_pkg.sv
// Shared definitions for the register-file command controller.
// Holds the FSM state encoding, default opcodes and register data width.
// No logic; imported by reg_file_sys_ctrl.
package reg_file_ctrl_pkg;

  // Register-file data width (data travels as two bytes, high then low)
  localparam int DATA_WIDTH = 16;

  // Default command opcodes
  localparam logic [7:0] WR_CMD_DEF = 8'hAA;
  localparam logic [7:0] RD_CMD_DEF = 8'hBB;

  // Controller states
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_ADDR = 4'd1,
    ST_WR_DH   = 4'd2,
    ST_WR_DL   = 4'd3,
    ST_WR_EXEC = 4'd4,
    ST_RD_ADDR = 4'd5,
    ST_RD_EXEC = 4'd6,
    ST_RD_WAIT = 4'd7,
    ST_TX_H    = 4'd8,
    ST_TX_L    = 4'd9
  } state_t;

endpackage

// File: rtl/reg_file_sys_ctrl.sv
// Parses serial command bytes into register-file writes/reads; returns read data as two TX bytes.
// Latency: WrEn one cycle after last write byte; RdEn one cycle after address byte, TX high byte 3 cycles after it.
// Backpressure: TX byte held with TX_D_VLD until TX_BUSY=0; RX bytes outside receive states are dropped.
module reg_file_sys_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int         ADDR_WIDTH = 4,
  parameter logic [7:0] WR_CMD     = WR_CMD_DEF,
  parameter logic [7:0] RD_CMD     = RD_CMD_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  TX_BUSY,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CTRL_BUSY
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [DATA_WIDTH-1:0]   r_rd_cap;
  logic                    r_ctrl_busy;
  logic                    w_tx_vld;
  logic                    w_tx_xfer;

  // A TX byte moves only when we offer it and the transmitter is free
  assign w_tx_vld  = (r_state == ST_TX_H) || (r_state == ST_TX_L);
  assign w_tx_xfer = w_tx_vld && !TX_BUSY;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; bytes arriving outside receive states never move the FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            w_state_nxt = ST_WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            w_state_nxt = ST_RD_ADDR;
          end
        end
      end
      ST_WR_ADDR: if (RX_D_VLD) w_state_nxt = ST_WR_DH;
      ST_WR_DH:   if (RX_D_VLD) w_state_nxt = ST_WR_DL;
      ST_WR_DL:   if (RX_D_VLD) w_state_nxt = ST_WR_EXEC;
      ST_WR_EXEC: w_state_nxt = ST_IDLE;
      ST_RD_ADDR: if (RX_D_VLD) w_state_nxt = ST_RD_EXEC;
      ST_RD_EXEC: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: w_state_nxt = ST_TX_H;
      ST_TX_H:    if (w_tx_xfer) w_state_nxt = ST_TX_L;
      ST_TX_L:    if (w_tx_xfer) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and TX byte decode purely from state, so they are glitch-free and
  // TX_P_DATA cannot change while a byte is being offered
  always_comb begin
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    TX_D_VLD  = w_tx_vld;
    TX_P_DATA = 8'h00;
    case (r_state)
      ST_WR_EXEC: WrEn      = 1'b1;
      ST_RD_EXEC: RdEn      = 1'b1;
      ST_TX_H:    TX_P_DATA = r_rd_cap[15:8];
      ST_TX_L:    TX_P_DATA = r_rd_cap[7:0];
      default:    ;
    endcase
  end

  // Byte assembler: address/data registers load as bytes arrive and hold afterwards;
  // read data is captured in the cycle after RdEn
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_address <= '0;
      r_wr_data <= '0;
      r_rd_cap  <= '0;
    end else begin
      if (RX_D_VLD && (r_state == ST_WR_ADDR || r_state == ST_RD_ADDR)) begin
        r_address <= RX_P_DATA[ADDR_WIDTH-1:0];
      end
      if (RX_D_VLD && r_state == ST_WR_DH) begin
        r_wr_data[15:8] <= RX_P_DATA;
      end
      if (RX_D_VLD && r_state == ST_WR_DL) begin
        r_wr_data[7:0] <= RX_P_DATA;
      end
      if (r_state == ST_RD_WAIT) begin
        r_rd_cap <= RdData;
      end
    end
  end

  // Busy flag registered from the next state so it tracks the state register exactly
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ctrl_busy <= 1'b0;
    end else begin
      r_ctrl_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign Address   = r_address;
  assign WrData    = r_wr_data;
  assign CTRL_BUSY = r_ctrl_busy;

endmodule

// File: tb/tb_reg_file_sys_ctrl.sv
// Self-checking bench for reg_file_sys_ctrl.
// Directed timing checks plus randomized command traffic against a command-level reference model.
// The register file itself is modelled behaviourally beside the DUT.
module tb_reg_file_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] RdData = 16'h0000;
  logic        TX_BUSY = 1'b0;
  logic        WrEn;
  logic        RdEn;
  logic [3:0]  Address;
  logic [15:0] WrData;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        CTRL_BUSY;

  reg_file_sys_ctrl #(.ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .TX_BUSY(TX_BUSY), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  // Behavioural register file driven by the DUT strobes
  logic [15:0] rf [16] = '{default: 16'h0000};
  always @(posedge CLK) begin
    if (WrEn) rf[Address] <= WrData;
    if (RdEn) RdData <= rf[Address];
  end

  // Reference model: memory contents implied by the commands sent, and the
  // transactions/bytes those commands must produce
  logic [15:0] ref_mem [16];
  logic [19:0] exp_wr_q [$];
  logic [3:0]  exp_rd_q [$];
  logic [7:0]  exp_tx_q [$];
  int          tx_cnt = 0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observe strobes and TX transfers once per cycle, mid-cycle
  task automatic monitor();
    logic [19:0] ew;
    logic [3:0]  ea;
    logic [7:0]  eb;
    if (RST) begin
      prev_hold = 1'b0;
      return;
    end
    if (WrEn && RdEn) chk("wr_rd_overlap", 1, 0);
    if (WrEn) begin
      if (exp_wr_q.size() == 0) chk("wr_unexpected", {Address, WrData}, 0);
      else begin
        ew = exp_wr_q.pop_front();
        chk("wr_addr", Address, ew[19:16]);
        chk("wr_data", WrData, ew[15:0]);
      end
    end
    if (RdEn) begin
      if (exp_rd_q.size() == 0) chk("rd_unexpected", Address, 0);
      else begin
        ea = exp_rd_q.pop_front();
        chk("rd_addr", Address, ea);
      end
    end
    if (TX_D_VLD && prev_hold) chk("tx_stable", TX_P_DATA, prev_byte);
    if (TX_D_VLD && !TX_BUSY) begin
      if (exp_tx_q.size() == 0) chk("tx_unexpected", TX_P_DATA, 0);
      else begin
        eb = exp_tx_q.pop_front();
        chk("tx_byte", TX_P_DATA, eb);
      end
      tx_cnt++;
    end
    prev_hold = TX_D_VLD && TX_BUSY;
    prev_byte = TX_P_DATA;
  endtask

  // One clock cycle: sample at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  // Sends a full write; returns in the cycle where WrEn is due
  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit rnd);
    logic [7:0] b [3];
    exp_wr_q.push_back({a[3:0], d});
    ref_mem[a[3:0]] = d;
    b[0] = a; b[1] = d[15:8]; b[2] = d[7:0];
    send_byte(8'hAA);
    if (!rnd) chk("busy_after_op", CTRL_BUSY, 1);
    for (int i = 0; i < 3; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) tick();
      send_byte(b[i]);
    end
  endtask

  // Sends a read and runs it to completion with random TX stalls and dropped bytes
  task automatic do_read_rnd(input logic [7:0] a);
    int target;
    exp_rd_q.push_back(a[3:0]);
    exp_tx_q.push_back(ref_mem[a[3:0]][15:8]);
    exp_tx_q.push_back(ref_mem[a[3:0]][7:0]);
    target = tx_cnt + 2;
    send_byte(8'hBB);
    repeat ($urandom_range(0, 2)) tick();
    send_byte(a);
    for (int k = 0; k < 300 && tx_cnt < target; k++) begin
      TX_BUSY   = ($urandom_range(0, 2) == 0);
      RX_P_DATA = 8'($urandom_range(0, 255));
      RX_D_VLD  = ($urandom_range(0, 3) == 0);
      tick();
      RX_D_VLD  = 1'b0;
    end
    TX_BUSY = 1'b0;
    if (tx_cnt < target) chk("rd_timeout", tx_cnt, target);
  endtask

  initial begin
    logic [7:0] jb;
    int         op;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;

    // Reset
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("rst_wren", WrEn, 0);
    chk("rst_rden", RdEn, 0);
    chk("rst_addr", Address, 0);
    chk("rst_wrdata", WrData, 0);
    chk("rst_txdata", TX_P_DATA, 0);
    chk("rst_txvld", TX_D_VLD, 0);
    chk("rst_busy", CTRL_BUSY, 0);

    // Write AA,02,AB,CD
    do_write(8'h02, 16'hABCD, 0);
    chk("wr_en_n1", WrEn, 1);
    chk("wr_addr_n1", Address, 2);
    chk("wr_data_n1", WrData, 16'hABCD);
    tick();
    chk("wr_en_n2", WrEn, 0);
    chk("wr_idle_n2", CTRL_BUSY, 0);

    // Read BB,02 with no stall: exact cycle timing
    exp_rd_q.push_back(4'd2);
    exp_tx_q.push_back(8'hAB);
    exp_tx_q.push_back(8'hCD);
    ref_mem[2] = 16'hABCD;
    send_byte(8'hBB);
    send_byte(8'h02);
    chk("rd_en_n1", RdEn, 1);
    chk("rd_addr_n1", Address, 2);
    tick();
    chk("rd_en_n2", RdEn, 0);
    chk("rd_txvld_n2", TX_D_VLD, 0);
    tick();
    chk("rd_txvld_n3", TX_D_VLD, 1);
    chk("rd_hi_n3", TX_P_DATA, 8'hAB);
    tick();
    chk("rd_txvld_n4", TX_D_VLD, 1);
    chk("rd_lo_n4", TX_P_DATA, 8'hCD);
    tick();
    chk("rd_txvld_n5", TX_D_VLD, 0);
    chk("rd_busy_n5", CTRL_BUSY, 0);

    // Read with 5-cycle TX stall; an opcode byte arrives during TX_H and must be dropped
    exp_rd_q.push_back(4'd2);
    exp_tx_q.push_back(8'hAB);
    exp_tx_q.push_back(8'hCD);
    send_byte(8'hBB);
    send_byte(8'h02);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      TX_BUSY = 1'b1;
      chk("stall_vld", TX_D_VLD, 1);
      chk("stall_hi", TX_P_DATA, 8'hAB);
      if (k == 2) begin RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1; end
      tick();
      RX_D_VLD = 1'b0;
    end
    TX_BUSY = 1'b0;
    chk("stall_release_hi", TX_P_DATA, 8'hAB);
    tick();
    chk("stall_lo", TX_P_DATA, 8'hCD);
    chk("stall_lo_vld", TX_D_VLD, 1);
    tick();
    chk("stall_done_vld", TX_D_VLD, 0);
    chk("stall_done_busy", CTRL_BUSY, 0);

    // Junk byte in IDLE is ignored
    send_byte(8'h55);
    chk("junk_idle", CTRL_BUSY, 0);

    // Upper address bits discarded
    do_write(8'hF4, 16'h5A5A, 0);
    chk("addr_trunc", Address, 4);
    tick();

    // Abort mid-command, then a clean write to the same address
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h12);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", CTRL_BUSY, 0);
    chk("abort_wrdata", WrData, 0);
    do_write(8'h04, 16'h1234, 0);
    chk("abort_retry_addr", Address, 4);
    chk("abort_retry_data", WrData, 16'h1234);
    tick();

    // Reset coinciding with the last write byte: no strobe next cycle
    send_byte(8'hAA); send_byte(8'h06); send_byte(8'h77);
    RX_P_DATA = 8'h88; RX_D_VLD = 1'b1; RST = 1'b1;
    tick();
    RX_D_VLD = 1'b0; RST = 1'b0;
    chk("exec_abort_wren", WrEn, 0);
    tick();

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      chk("rnd_idle", CTRL_BUSY, 0);
      op = $urandom_range(0, 2);
      if (op == 0) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hAA || jb == 8'hBB) jb = 8'h3C;
        send_byte(jb);
      end else if (op == 1) begin
        do_write(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 1);
        RX_P_DATA = 8'($urandom_range(0, 255));
        RX_D_VLD  = ($urandom_range(0, 1) == 0);
        tick();
        RX_D_VLD  = 1'b0;
      end else begin
        do_read_rnd(8'($urandom_range(0, 255)));
      end
    end
    tick(); tick();

    chk("end_wr_q", exp_wr_q.size(), 0);
    chk("end_rd_q", exp_rd_q.size(), 0);
    chk("end_tx_q", exp_tx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
